stdcore_2prf_bank: RTL and testbench

Parametrised, banked two-port register file for on-chip buffers. One write port and one read port share a single clock. Storage is split into NBANK equal banks; only the addressed bank is enabled per access. Beyond the basic two-port file, it adds:
- a bit-level write mask;
- a registered read-valid flag;
- defined same-address read/write collision behaviour;
- a saturating collision counter for debug.

---
 rtl/stdcore_2prf_bank.sv | 117 +++++++++++
 tb/tb_stdcore_2prf_bank.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/stdcore_2prf_bank.sv
// Banked two-port register file: masked writes, registered reads, collision pulse and saturating counter.
// Define STDCORE_2PRF_BYPASS_EN for write-first forwarding on same-address collisions (default: read-first).
module stdcore_2prf_bank #(
   parameter int DW    = 16,
   parameter int DEPTH = 256,
   parameter int NBANK = 2,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = 8
) (
   input  logic          rclk,
   input  logic          arst_n,
   input  logic          we_n,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [DW-1:0] wmask,
   input  logic          re_n,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          coll,
   output logic [CW-1:0] coll_cnt
);

   localparam int BS = DEPTH / NBANK;
   localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
   localparam int WW = (BS > 1) ? $clog2(BS) : 1;
   localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] BS_A    = AW'(BS);

   function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] a);
      logic [AW-1:0] q;
      q = a / BS_A;
      return q[BW-1:0];
   endfunction

   function automatic logic [WW-1:0] word_of(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      r = a % BS_A;
      return r[WW-1:0];
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] d,
                                           input logic [DW-1:0] m);
      return (old_w & ~m) | (d & m);
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (&c) ? c : c + CW'(1);
   endfunction

   // p0: address decode; reset gates enables so an access on the reset edge is discarded
   logic          w_in_p0, r_in_p0, w_en_p0, r_en_p0, coll_p0;
   logic [BW-1:0] wbank_p0, rbank_p0;
   logic [WW-1:0] wword_p0, rword_p0;

   assign w_in_p0  = {1'b0, waddr} < DEPTH_X;
   assign r_in_p0  = {1'b0, raddr} < DEPTH_X;
   assign w_en_p0  = ~we_n & arst_n & w_in_p0;
   assign r_en_p0  = ~re_n & arst_n;
   assign coll_p0  = w_en_p0 & r_en_p0 & r_in_p0 & (raddr == waddr);
   assign wbank_p0 = bank_of(waddr);
   assign rbank_p0 = bank_of(raddr);
   assign wword_p0 = word_of(waddr);
   assign rword_p0 = word_of(raddr);

   // p1: per-bank storage and read registers
   logic [DW-1:0] bank_q [NBANK];

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      logic [DW-1:0] mem [BS];
      logic [DW-1:0] rd_p1;

      always_ff @(posedge rclk) begin
         if (w_en_p0 && (wbank_p0 == BW'(b)))
            mem[wword_p0] <= merge(mem[wword_p0], wdata, wmask);
         if (r_en_p0 && r_in_p0 && (rbank_p0 == BW'(b))) begin
`ifdef STDCORE_2PRF_BYPASS_EN
            rd_p1 <= coll_p0 ? merge(mem[rword_p0], wdata, wmask) : mem[rword_p0];
`else
            rd_p1 <= mem[rword_p0];
`endif
         end
      end

      assign bank_q[b] = rd_p1;
   end

   logic [BW-1:0] rsel_p1;
   logic          rzero_p1, vld_p1, coll_p1;
   logic [CW-1:0] cnt_p1;

   always_ff @(posedge rclk or negedge arst_n) begin
      if (!arst_n) begin
         rsel_p1  <= '0;
         rzero_p1 <= 1'b1;
         vld_p1   <= 1'b0;
         coll_p1  <= 1'b0;
         cnt_p1   <= '0;
      end else begin
         vld_p1  <= r_en_p0;
         coll_p1 <= coll_p0;
         if (coll_p0)
            cnt_p1 <= sat_inc(cnt_p1);
         if (r_en_p0) begin
            rsel_p1  <= rbank_p0;
            rzero_p1 <= ~r_in_p0;
         end
      end
   end

   // rzero covers both reset and out-of-range reads without clearing the bank registers
   assign rdata    = rzero_p1 ? '0 : bank_q[rsel_p1];
   assign rvalid   = vld_p1;
   assign coll     = coll_p1;
   assign coll_cnt = cnt_p1;

endmodule

// File: tb/tb_stdcore_2prf_bank.sv
// Bench for stdcore_2prf_bank (DEPTH=192, NBANK=2, CW=4) against an array-level reference model.
module tb_stdcore_2prf_bank;

   localparam int DW    = 16;
   localparam int DEPTH = 192;
   localparam int NBANK = 2;
   localparam int AW    = 8;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;
`ifdef STDCORE_2PRF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          rclk, arst_n, we_n, re_n;
   logic [AW-1:0] waddr, raddr;
   logic [DW-1:0] wdata, wmask, rdata;
   logic          rvalid, coll;
   logic [CW-1:0] coll_cnt;

   stdcore_2prf_bank #(.DW(DW), .DEPTH(DEPTH), .NBANK(NBANK), .AW(AW), .CW(CW)) dut (
      .rclk(rclk), .arst_n(arst_n), .we_n(we_n), .waddr(waddr), .wdata(wdata), .wmask(wmask),
      .re_n(re_n), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .coll(coll), .coll_cnt(coll_cnt)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   logic [DW-1:0] m_mem   [DEPTH];
   bit            m_known [DEPTH];
   logic [DW-1:0] e_rdata;
   bit            e_known, e_vld, e_coll;
   int            e_cnt;
   int            n_vec, n_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      if (e_known) check("rdata", 32'(rdata), 32'(e_rdata));
      check("rvalid", 32'(rvalid), 32'(e_vld));
      check("coll", 32'(coll), 32'(e_coll));
      check("coll_cnt", 32'(coll_cnt), 32'(e_cnt));
   endtask

   task automatic cyc(input bit we, input int wa, input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                      input bit re, input int ra);
      bit c;
      @(negedge rclk);
      we_n = ~we; waddr = AW'(wa); wdata = wd; wmask = wm;
      re_n = ~re; raddr = AW'(ra);
      @(posedge rclk);
      #1;
      c = we && re && (wa == ra) && (wa < DEPTH);
      if (re) begin
         e_vld = 1'b1;
         if (ra >= DEPTH) begin
            e_rdata = '0;
            e_known = 1'b1;
         end else if (c && BYP) begin
            e_rdata = (m_mem[ra] & ~wm) | (wd & wm);
            e_known = m_known[ra] || (wm == '1);
         end else begin
            e_rdata = m_mem[ra];
            e_known = m_known[ra];
         end
      end else begin
         e_vld = 1'b0;
      end
      e_coll = c;
      if (c && e_cnt < CMAX) e_cnt++;
      if (we && wa < DEPTH) begin
         m_mem[wa]   = (m_mem[wa] & ~wm) | (wd & wm);
         m_known[wa] = m_known[wa] || (wm == '1);
      end
      check_outputs();
   endtask

   task automatic idle();
      cyc(1'b0, 0, '0, '0, 1'b0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int wa, ra, sel;
      logic [DW-1:0] wm;
      n_vec = 0; n_fail = 0;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
      e_rdata = '0; e_known = 1'b1; e_vld = 1'b0; e_coll = 1'b0; e_cnt = 0;
      arst_n = 1'b0; we_n = 1'b1; re_n = 1'b1;
      waddr = '0; raddr = '0; wdata = '0; wmask = '0;

      repeat (3) @(posedge rclk);
      #1;
      check_outputs();
      @(negedge rclk);
      arst_n = 1'b1;

      // first read after reset: value undefined, valid must rise
      cyc(1'b0, 0, '0, '0, 1'b1, 0);

      cyc(1'b1, 5, 16'hFFFF, 16'hFFFF, 1'b0, 0);
      cyc(1'b1, 5, 16'h1234, 16'h00FF, 1'b0, 0);
      cyc(1'b1, 133, 16'hABCD, 16'hFFFF, 1'b0, 0);
      cyc(1'b0, 0, '0, '0, 1'b1, 5);
      check("masked_rd5", 32'(rdata), 32'h0000FF34);
      cyc(1'b0, 0, '0, '0, 1'b1, 133);
      check("bank1_rd133", 32'(rdata), 32'h0000ABCD);
      idle();

      cyc(1'b1, 7, 16'h1111, 16'hFFFF, 1'b0, 0);
      cyc(1'b1, 7, 16'h2222, 16'hFFFF, 1'b1, 7);
      check("coll_rdata", 32'(rdata), BYP ? 32'h2222 : 32'h1111);
      check("coll_cnt1", 32'(coll_cnt), 32'd1);
      idle();
      cyc(1'b0, 0, '0, '0, 1'b1, 7);
      check("rd7_after", 32'(rdata), 32'h2222);

      cyc(1'b1, 8, 16'h5A5A, 16'hFFFF, 1'b0, 0);
      cyc(1'b1, 200, 16'hDEAD, 16'hFFFF, 1'b0, 0);
      cyc(1'b0, 0, '0, '0, 1'b1, 200);
      check("oor_rdata", 32'(rdata), 32'd0);
      cyc(1'b0, 0, '0, '0, 1'b1, 8);
      check("rd8_kept", 32'(rdata), 32'h5A5A);
      cyc(1'b1, 95, 16'h0095, 16'hFFFF, 1'b0, 0);
      cyc(1'b1, 96, 16'h0096, 16'hFFFF, 1'b0, 0);
      cyc(1'b0, 0, '0, '0, 1'b1, 95);
      cyc(1'b0, 0, '0, '0, 1'b1, 96);
      check("rd96_bank1", 32'(rdata), 32'h0096);

      for (int i = 0; i < 20; i++) cyc(1'b1, 3, DW'(i), 16'hFFFF, 1'b1, 3);
      check("sat_cnt", 32'(coll_cnt), 32'(CMAX));
      idle();

      for (int a = 0; a < DEPTH; a++) cyc(1'b1, a, DW'($urandom), 16'hFFFF, 1'b0, 0);
      for (int i = 0; i < 400; i++) begin
         wa  = int'($urandom_range(0, 255));
         ra  = ($urandom % 4 == 0) ? wa : int'($urandom_range(0, 255));
         sel = int'($urandom % 4);
         wm  = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0000 : DW'($urandom);
         cyc($urandom % 4 != 0, wa, DW'($urandom), wm, $urandom % 4 != 0, ra);
      end

      // read burst interrupted by asynchronous reset between edges
      for (int a = 10; a < 14; a++) cyc(1'b1, a + 20, DW'($urandom), 16'hFFFF, 1'b1, a);
      #2;
      arst_n = 1'b0;
      #1;
      e_rdata = '0; e_known = 1'b1; e_vld = 1'b0; e_coll = 1'b0; e_cnt = 0;
      check_outputs();
      @(negedge rclk);
      we_n = 1'b0; waddr = AW'(10); wdata = 16'hBEEF; wmask = 16'hFFFF;
      re_n = 1'b0; raddr = AW'(10);
      @(posedge rclk);
      #1;
      check_outputs();
      @(negedge rclk);
      we_n = 1'b1; re_n = 1'b1;
      arst_n = 1'b1;
      for (int a = 10; a < 14; a++) cyc(1'b0, 0, '0, '0, 1'b1, a);
      cyc(1'b0, 0, '0, '0, 1'b1, 133);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
